// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between fetch and data: one transaction in flight, data priority with a fetch starvation bound.
// Grant is combinational in IDLE, 3-cycle minimum per access; requesters stall until granted and until their response returns.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_f_o,
    output logic              stall_m_o,
    output logic              err_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t     state_q;
    owner_t     owner_q;
    cmd_t       cmd_q, cmd_d;
    logic [3:0] streak_q, streak_d;
    logic       err_q;
    logic       mem_req_q;

    logic idle;
    logic d_win;
    logic if_win;
    logic rsp_fire;

    // Data wins by default; a pending fetch takes the port once data has had its full streak.
    assign idle     = (state_q == ST_IDLE);
    assign d_win    = d_req_i & ~(if_req_i & (streak_q == STREAK_MAX));
    assign if_win   = if_req_i & ~d_win;
    assign if_gnt_o = idle & if_win;
    assign d_gnt_o  = idle & d_win;
    assign rsp_fire = (state_q == ST_WAIT) & mem_rvalid_i;

    always_comb begin
        streak_d = streak_q;
        if (!if_req_i || if_gnt_o) begin
            streak_d = '0;
        end else if (d_gnt_o && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_comb begin
        cmd_d = cmd_q;
        if (d_gnt_o) begin
            cmd_d = '{we: d_we_i, addr: d_addr_i, wdata: d_wdata_i};
        end else if (if_gnt_o) begin
            cmd_d = '{we: 1'b0, addr: if_addr_i, wdata: '0};
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IF;
            cmd_q     <= '0;
            streak_q  <= '0;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            cmd_q    <= cmd_d;
            streak_q <= streak_d;
            // Any response not expected by a transaction in WAIT is a protocol error and is dropped.
            if (mem_rvalid_i && (state_q != ST_WAIT)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (if_gnt_o || d_gnt_o) begin
                        state_q   <= ST_ISSUE;
                        owner_q   <= d_gnt_o ? OWN_D : OWN_IF;
                        mem_req_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ack_i) begin
                        state_q   <= ST_WAIT;
                        mem_req_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = cmd_q.we;
    assign mem_addr_o  = cmd_q.addr;
    assign mem_wdata_o = cmd_q.wdata;

    assign if_rvalid_o = rsp_fire & (owner_q == OWN_IF);
    assign d_rvalid_o  = rsp_fire & (owner_q == OWN_D);
    assign if_rdata_o  = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;

    assign stall_f_o = (if_req_i & ~if_gnt_o) | ((owner_q == OWN_IF) & ~idle & ~if_rvalid_o);
    assign stall_m_o = (d_req_i & ~d_gnt_o) | ((owner_q == OWN_D) & ~idle & ~d_rvalid_o);
    assign err_o     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MAX_D_STREAK=2; inputs change 1ns after posedge, outputs sampled on negedge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_f, stall_m, err;

    int n_vec  = 0;
    int n_miss = 0;

    bit exp_d [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(2)) dut (
        .clk(clk), .nrst(nrst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .stall_f_o(stall_f), .stall_m_o(stall_m), .err_o(err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        nrst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset state
        nxt(); nxt();
        smp();
        check_val("rst_if_gnt", if_gnt, 0);
        check_val("rst_d_gnt", d_gnt, 0);
        check_val("rst_mem_req", mem_req, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_wdata", mem_wdata, 0);
        check_val("rst_mem_we", mem_we, 0);
        check_val("rst_stall_f", stall_f, 0);
        check_val("rst_stall_m", stall_m, 0);
        check_val("rst_err", err, 0);
        check_val("rst_rvalid", {if_rvalid, d_rvalid}, 0);
        nxt(); nrst = 1'b1;
        smp();
        check_val("idle_no_gnt", {if_gnt, d_gnt}, 0);

        // Single fetch, ack immediately, response two cycles after grant+1
        nxt(); if_req = 1'b1; if_addr = 32'h100;
        smp();
        check_val("f1_if_gnt", if_gnt, 1);
        check_val("f1_d_gnt", d_gnt, 0);
        nxt(); if_req = 1'b0; mem_ack = 1'b1;
        smp();
        check_val("f1_mem_req", mem_req, 1);
        check_val("f1_mem_addr", mem_addr, 32'h100);
        check_val("f1_mem_we", mem_we, 0);
        check_val("f1_stall_f_issue", stall_f, 1);
        nxt(); mem_ack = 1'b0;
        smp();
        check_val("f1_mem_req_off", mem_req, 0);
        check_val("f1_stall_f_wait", stall_f, 1);
        check_val("f1_if_rvalid_early", if_rvalid, 0);
        nxt(); mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        smp();
        check_val("f1_if_rvalid", if_rvalid, 1);
        check_val("f1_if_rdata", if_rdata, 32'hDEADBEEF);
        check_val("f1_d_rvalid", d_rvalid, 0);
        check_val("f1_stall_f_done", stall_f, 0);
        nxt(); mem_rvalid = 1'b0;
        smp();
        check_val("f1_if_rvalid_pulse", if_rvalid, 0);

        // Simultaneous fetch and load: data first, fetch right after
        nxt(); if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        smp();
        check_val("sim_d_gnt", d_gnt, 1);
        check_val("sim_if_gnt", if_gnt, 0);
        check_val("sim_stall_f", stall_f, 1);
        check_val("sim_stall_m", stall_m, 0);
        nxt(); d_req = 1'b0; mem_ack = 1'b1;
        smp();
        check_val("sim_mem_addr", mem_addr, 32'h200);
        check_val("sim_stall_f_issue", stall_f, 1);
        check_val("sim_stall_m_issue", stall_m, 1);
        nxt(); mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        smp();
        check_val("sim_d_rvalid", d_rvalid, 1);
        check_val("sim_d_rdata", d_rdata, 32'hCAFEF00D);
        check_val("sim_if_rvalid", if_rvalid, 0);
        check_val("sim_stall_f_wait", stall_f, 1);
        check_val("sim_stall_m_done", stall_m, 0);
        check_val("sim_if_gnt_wait", if_gnt, 0);
        nxt(); mem_rvalid = 1'b0;
        smp();
        check_val("sim_if_gnt_next", if_gnt, 1);
        nxt(); if_req = 1'b0; mem_ack = 1'b1;
        smp();
        check_val("sim_if_mem_addr", mem_addr, 32'h300);
        nxt(); mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        smp();
        check_val("sim_if_rvalid", if_rvalid, 1);
        nxt(); mem_rvalid = 1'b0;

        // Starvation guard: both held, order D,D,IF,D,D,IF
        if_req = 1'b1; if_addr = 32'h900; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
        for (int k = 0; k < 6; k++) begin
            smp();
            check_val($sformatf("stv_d_gnt%0d", k), d_gnt, exp_d[k]);
            check_val($sformatf("stv_if_gnt%0d", k), if_gnt, !exp_d[k]);
            nxt(); mem_ack = 1'b1;
            smp();
            check_val($sformatf("stv_addr%0d", k), mem_addr, exp_d[k] ? 32'h800 : 32'h900);
            nxt(); mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'(k);
            smp();
            check_val($sformatf("stv_d_rv%0d", k), d_rvalid, exp_d[k]);
            check_val($sformatf("stv_if_rv%0d", k), if_rvalid, !exp_d[k]);
            nxt(); mem_rvalid = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;

        // Store with ack held off for three cycles
        nxt(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
        smp();
        check_val("st_d_gnt", d_gnt, 1);
        for (int i = 0; i < 4; i++) begin
            nxt(); d_req = 1'b0; d_we = 1'b0; d_wdata = '0; mem_ack = (i == 3);
            smp();
            check_val($sformatf("st_req%0d", i), mem_req, 1);
            check_val($sformatf("st_addr%0d", i), mem_addr, 32'h40);
            check_val($sformatf("st_wdata%0d", i), mem_wdata, 32'h1234);
            check_val($sformatf("st_we%0d", i), mem_we, 1);
            check_val($sformatf("st_stall_m%0d", i), stall_m, 1);
        end
        nxt(); mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
        smp();
        check_val("st_d_rvalid", d_rvalid, 1);
        check_val("st_mem_req_off", mem_req, 0);
        check_val("st_stall_m_done", stall_m, 0);
        nxt(); mem_rvalid = 1'b0;

        // Reset while in WAIT, then a late response
        if_req = 1'b1; if_addr = 32'h500;
        smp();
        check_val("rw_if_gnt", if_gnt, 1);
        nxt(); if_req = 1'b0; mem_ack = 1'b1;
        smp();
        nxt(); mem_ack = 1'b0; nrst = 1'b0;
        smp();
        check_val("rw_stall_f_wait", stall_f, 1);
        nxt(); nrst = 1'b1;
        smp();
        check_val("rw_stall_f_rst", stall_f, 0);
        check_val("rw_err_clear", err, 0);
        check_val("rw_mem_addr_rst", mem_addr, 0);
        nxt(); mem_rvalid = 1'b1; mem_rdata = 32'h5555;
        smp();
        check_val("rw_late_rvalid", {if_rvalid, d_rvalid}, 0);
        nxt(); mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h600;
        smp();
        check_val("rw_err_set", err, 1);
        check_val("rw_if_gnt2", if_gnt, 1);
        nxt(); if_req = 1'b0; mem_ack = 1'b1;
        smp();
        check_val("rw_mem_addr2", mem_addr, 32'h600);
        nxt(); mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h600DF00D;
        smp();
        check_val("rw_if_rvalid2", if_rvalid, 1);
        check_val("rw_if_rdata2", if_rdata, 32'h600DF00D);
        check_val("rw_err_sticky", err, 1);
        nxt(); mem_rvalid = 1'b0;

        // Response in the ack cycle is an error and is dropped
        nrst = 1'b0;
        nxt(); nrst = 1'b1;
        smp();
        check_val("ar_err_clear", err, 0);
        nxt(); if_req = 1'b1; if_addr = 32'h700;
        smp();
        check_val("ar_if_gnt", if_gnt, 1);
        nxt(); if_req = 1'b0; mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        smp();
        check_val("ar_if_rvalid_drop", if_rvalid, 0);
        nxt(); mem_ack = 1'b0; mem_rvalid = 1'b0;
        smp();
        check_val("ar_err_set", err, 1);
        check_val("ar_mem_req", mem_req, 0);
        check_val("ar_stall_f", stall_f, 1);
        nxt();
        smp();
        check_val("ar_stall_f_hold", stall_f, 1);
        nxt(); mem_rvalid = 1'b1; mem_rdata = 32'h77;
        smp();
        check_val("ar_if_rvalid", if_rvalid, 1);
        check_val("ar_if_rdata", if_rdata, 32'h77);
        nxt(); mem_rvalid = 1'b0;
        smp();
        check_val("ar_if_rvalid_pulse", if_rvalid, 0);
        check_val("ar_stall_f_done", stall_f, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port between the instruction-fetch path (icache refill) and the data path (loads/stores) of the RISC-V pipeline. It arbitrates one outstanding transaction at a time, with data priority and a bounded-starvation guard for fetch. It steers the response back to the owner and drives the fetch/memory stall lines consumed by the control unit.

## Interface

- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, max consecutive data grants while if_req is pending (range 1–15)

- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid (1-cycle pulse)
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid / store complete (1-cycle pulse)
- d_rdata  out  DATA_W  load data
- mem_req  out  1  command valid to memory
- mem_we  out  1  command is write
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  memory accepted command (qualified by mem_req)
- mem_rvalid  in  1  response valid (read data or write completion)
- mem_rdata  in  DATA_W  read data
- stall_f  out  1  fetch waiting on arbiter
- stall_m  out  1  data access waiting on arbiter
- err  out  1  sticky: mem_rvalid outside WAIT

## Operation

- FSM states: IDLE, ISSUE, WAIT. Registers: owner (IF/D), cmd_we, cmd_addr, cmd_wdata, streak counter (4 bits).
- IDLE: if any request is pending, select a winner. gnt is combinational, high only in IDLE for the winner. On that edge, capture addr/we/wdata and owner, then go to ISSUE. Fetch grants force cmd_we=0.
- Selection: d_req wins unless if_req=1 and streak==MAX_D_STREAK, in which case IF wins. If only one is requesting, that one wins.
- Streak: +1 on each data grant while if_req=1 (saturating at MAX_D_STREAK). Cleared on an IF grant, and in any cycle where if_req=0.
- ISSUE: mem_req=1 and mem_addr/we/wdata come from the registers, held stable. On mem_ack, go to WAIT.
- WAIT: on mem_rvalid, pulse owner's x_rvalid in the same cycle and set x_rdata=mem_rdata (combinational pass-through), then go to IDLE. The non-owner's rvalid stays 0. A store completes when d_rvalid is pulsed.
- mem_rvalid in IDLE or ISSUE: ignored for the requesters and sets err=1. err clears only on reset.
- stall_f = (if_req & ~if_gnt) | (owner==IF & state!=IDLE & ~if_rvalid). stall_m is the same using the d_ signals.
- x_rdata is don't-care when x_rvalid=0. It is driven as mem_rdata.

## Timing

- Reset values: state=IDLE, streak=0, owner=IF, err=0. All gnt/rvalid/mem_req/stall outputs are 0 when no request is present. mem_addr, mem_wdata and mem_we are 0.
- Minimum transaction: grant at cycle T, mem_req from T+1, mem_ack at T+1, WAIT from T+2, mem_rvalid at T+2 → x_rvalid at T+2, IDLE at T+3, next grant no earlier than T+3. Period is 3 cycles per access.
- mem_req stays high for as many cycles as mem_ack is low. No timeout.
- Memory must not respond in the cycle of mem_ack. A response in that cycle sets err and is dropped.
- Simultaneous if_req and d_req in IDLE: exactly one gnt. The loser keeps stall high.
- Reset mid-transaction: next cycle is IDLE. The outstanding response is discarded. A late mem_rvalid after reset sets err.
- Requests deasserted before grant: this is illegal. The behaviour is defined as "no grant issued".

## Test plan

- Single fetch: if_req, addr 0x100, mem acks immediately, rvalid 2 cycles later with 0xDEADBEEF → if_gnt at T, mem_req T+1..T+1, if_rvalid at T+3 with 0xDEADBEEF, stall_f high T..T+2.
- Simultaneous if_req and d_req (load 0x200) → d_gnt first. The fetch is granted in the IDLE cycle after d_rvalid, and stall_f stays high throughout.
- Starvation with MAX_D_STREAK=2, d_req held continuously and if_req held → grant order is D, D, IF, D, D, IF.
- Store d_we=1, addr 0x40, data 0x1234, mem_ack delayed 3 cycles → mem_req high with stable addr/data for 4 cycles, mem_we=1, d_rvalid on write completion.
- Reset in WAIT, then mem_rvalid 1 cycle after reset release → no rvalid to either requester, err=1, state IDLE. A following fetch completes normally.
- mem_rvalid in the same cycle as mem_ack → err=1, no x_rvalid, FSM stays in WAIT until the next mem_rvalid.
